// File: rtl/branch_checkpoint_queue.sv
// -----------------------------------------------------------------------------
// branch_checkpoint_queue
//
// In-order queue of per-branch perceptron prediction checkpoints. Decode pushes
// one checkpoint per predicted branch; execute resolves branches oldest-first.
// Each resolve pops the head and may produce a registered training packet for
// the perceptron trainer and, on a mispredict, a GHR restore value. A
// mispredict or an external flush discards every younger (wrong-path) entry.
//
// Ports:
//   clk, rst_n          clock; asynchronous ACTIVE-HIGH reset (legacy name)
//   alloc_*             decode push: valid/ready handshake plus PC, perceptron
//                       index, GHR snapshot, predicted direction, signed sum
//   resolve_*           execute result for the oldest branch: PC and outcome
//   flush               external pipeline flush, empties the queue
//   train_*             registered 1-cycle training packet
//   restore_*           registered 1-cycle GHR restore packet
//   count/empty/full    occupancy
//   pc_mismatch         sticky error: resolve PC differed from head PC, or a
//                       resolve arrived while the queue was empty
// -----------------------------------------------------------------------------
module branch_checkpoint_queue #(
  parameter int DEPTH        = 8,
  parameter int HISTORY_SIZE = 64,
  parameter int IDX_WIDTH    = 6,
  parameter int ADDR_WIDTH   = 32,
  parameter int SUM_WIDTH    = 16,
  parameter int THETA        = 137
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [ADDR_WIDTH-1:0]    alloc_pc,
  input  logic [IDX_WIDTH-1:0]     alloc_index,
  input  logic [HISTORY_SIZE-1:0]  alloc_history,
  input  logic                     alloc_prediction,
  input  logic [SUM_WIDTH-1:0]     alloc_sum,
  input  logic                     resolve_valid,
  input  logic [ADDR_WIDTH-1:0]    resolve_pc,
  input  logic                     resolve_taken,
  input  logic                     flush,
  output logic                     train_valid,
  output logic [IDX_WIDTH-1:0]     train_index,
  output logic [HISTORY_SIZE-1:0]  train_history,
  output logic                     train_taken,
  output logic                     train_mispredict,
  output logic                     restore_valid,
  output logic [HISTORY_SIZE-1:0]  restore_history,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     pc_mismatch
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [SUM_WIDTH:0] THETA_V = (SUM_WIDTH + 1)'(THETA);
  localparam logic [PTR_W:0]     PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0] head, tail, head_next;

  logic [ADDR_WIDTH-1:0]   pc_mem   [DEPTH];
  logic [IDX_WIDTH-1:0]    idx_mem  [DEPTH];
  logic [HISTORY_SIZE-1:0] hist_mem [DEPTH];
  logic                    pred_mem [DEPTH];
  logic [SUM_WIDTH-1:0]    sum_mem  [DEPTH];

  logic [PTR_W-1:0]        head_slot;
  logic                    do_resolve, pc_ok, mis, squash, alloc_fire;
  logic                    train_fire, restore_fire, mismatch_set;
  logic [SUM_WIDTH:0]      sum_ext, abs_sum;

  assign empty       = (head == tail);
  assign full        = (head[PTR_W] != tail[PTR_W]) &&
                       (head[PTR_W-1:0] == tail[PTR_W-1:0]);
  assign count       = tail - head;
  assign alloc_ready = !full;
  assign head_slot   = head[PTR_W-1:0];

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    do_resolve   = 1'b0;
    pc_ok        = 1'b0;
    mis          = 1'b0;
    sum_ext      = '0;
    abs_sum      = '0;
    train_fire   = 1'b0;
    restore_fire = 1'b0;
    squash       = 1'b0;
    alloc_fire   = 1'b0;
    mismatch_set = 1'b0;
    head_next    = head;

    do_resolve = resolve_valid && !empty;
    pc_ok      = (resolve_pc == pc_mem[head_slot]);
    mis        = pred_mem[head_slot] ^ resolve_taken;

    // One extra bit so the magnitude of the most negative sum is representable.
    sum_ext = {sum_mem[head_slot][SUM_WIDTH-1], sum_mem[head_slot]};
    abs_sum = sum_ext[SUM_WIDTH] ? -sum_ext : sum_ext;

    // A PC mismatch means the checkpoint cannot be trusted: pop it silently.
    train_fire   = do_resolve && pc_ok && (mis || (abs_sum <= THETA_V));
    restore_fire = do_resolve && pc_ok && mis;
    squash       = restore_fire;
    mismatch_set = (resolve_valid && empty) || (do_resolve && !pc_ok);

    // Allocation sees the pre-resolve occupancy; wrong-path pushes are dropped.
    alloc_fire = alloc_valid && !full && !flush && !squash;

    if (do_resolve) head_next = head + PTR_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head_next;
      // Flush and mispredict both leave the queue empty after the pop.
      if (flush || squash) tail <= head_next;
      else if (alloc_fire) tail <= tail + PTR_ONE;
    end
  end

  // NOTE: payload storage is deliberately left out of reset; validity is
  // tracked solely by the pointers, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_mem[tail[PTR_W-1:0]]   <= alloc_pc;
      idx_mem[tail[PTR_W-1:0]]  <= alloc_index;
      hist_mem[tail[PTR_W-1:0]] <= alloc_history;
      pred_mem[tail[PTR_W-1:0]] <= alloc_prediction;
      sum_mem[tail[PTR_W-1:0]]  <= alloc_sum;
    end
  end

  // Registered output packets: valid pulses for one cycle, data holds.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      train_valid      <= 1'b0;
      train_index      <= '0;
      train_history    <= '0;
      train_taken      <= 1'b0;
      train_mispredict <= 1'b0;
      restore_valid    <= 1'b0;
      restore_history  <= '0;
      pc_mismatch      <= 1'b0;
    end else begin
      train_valid   <= train_fire;
      restore_valid <= restore_fire;
      if (train_fire) begin
        train_index      <= idx_mem[head_slot];
        train_history    <= hist_mem[head_slot];
        train_taken      <= resolve_taken;
        train_mispredict <= mis;
      end
      if (restore_fire)
        restore_history <= {hist_mem[head_slot][HISTORY_SIZE-2:0], resolve_taken};
      if (mismatch_set) pc_mismatch <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_checkpoint_queue.sv
// -----------------------------------------------------------------------------
// Testbench for branch_checkpoint_queue: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_branch_checkpoint_queue;

  localparam int DEPTH = 8;
  localparam int THETA = 137;

  logic        clk, rst_n;
  logic        alloc_valid, alloc_ready;
  logic [31:0] alloc_pc;
  logic [5:0]  alloc_index;
  logic [63:0] alloc_history;
  logic        alloc_prediction;
  logic [15:0] alloc_sum;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic        flush;
  logic        train_valid;
  logic [5:0]  train_index;
  logic [63:0] train_history;
  logic        train_taken, train_mispredict;
  logic        restore_valid;
  logic [63:0] restore_history;
  logic [3:0]  count;
  logic        empty, full, pc_mismatch;

  branch_checkpoint_queue dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
    .alloc_index(alloc_index), .alloc_history(alloc_history),
    .alloc_prediction(alloc_prediction), .alloc_sum(alloc_sum),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .flush(flush),
    .train_valid(train_valid), .train_index(train_index),
    .train_history(train_history), .train_taken(train_taken),
    .train_mispredict(train_mispredict), .restore_valid(restore_valid),
    .restore_history(restore_history), .count(count), .empty(empty),
    .full(full), .pc_mismatch(pc_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  idx;
    logic [63:0] hist;
    logic        pred;
    logic [15:0] sum;
  } ent_t;

  // Reference model state.
  ent_t        q[$];
  logic        m_mism, m_tv, m_rv, m_ttaken, m_tmis;
  logic [5:0]  m_tidx;
  logic [63:0] m_thist, m_rhist;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mism = 0; m_tv = 0; m_rv = 0; m_ttaken = 0; m_tmis = 0;
    m_tidx = '0; m_thist = '0; m_rhist = '0;
  endtask

  task automatic clear_inputs();
    alloc_valid = 0; alloc_pc = '0; alloc_index = '0; alloc_history = '0;
    alloc_prediction = 0; alloc_sum = '0;
    resolve_valid = 0; resolve_pc = '0; resolve_taken = 0; flush = 0;
  endtask

  // Behavioural effect of one clock edge with the current inputs.
  task automatic model_edge();
    ent_t h, n;
    bit   accept, squash, wrong;
    int   s, a;
    squash = 0;
    m_tv = 0;
    m_rv = 0;
    accept = alloc_valid && (q.size() < DEPTH) && !flush;
    if (resolve_valid) begin
      if (q.size() == 0) m_mism = 1;
      else begin
        h = q.pop_front();
        if (resolve_pc != h.pc) m_mism = 1;
        else begin
          s = int'($signed(h.sum));
          a = (s < 0) ? -s : s;
          wrong = (h.pred != resolve_taken);
          if (wrong || a <= THETA) begin
            m_tv = 1; m_tidx = h.idx; m_thist = h.hist;
            m_ttaken = resolve_taken; m_tmis = wrong;
          end
          if (wrong) begin
            m_rv = 1; m_rhist = {h.hist[62:0], resolve_taken}; squash = 1;
          end
        end
      end
    end
    if (flush || squash) begin
      q.delete();
      accept = 0;
    end
    if (accept) begin
      n.pc = alloc_pc; n.idx = alloc_index; n.hist = alloc_history;
      n.pred = alloc_prediction; n.sum = alloc_sum;
      q.push_back(n);
    end
  endtask

  task automatic check_outputs();
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    check("full", full, q.size() == DEPTH);
    check("train_valid", train_valid, m_tv);
    check("train_index", train_index, m_tidx);
    check("train_history", train_history, m_thist);
    check("train_taken", train_taken, m_ttaken);
    check("train_mispredict", train_mispredict, m_tmis);
    check("restore_valid", restore_valid, m_rv);
    check("restore_history", restore_history, m_rhist);
    check("pc_mismatch", pc_mismatch, m_mism);
  endtask

  // Entered at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic step();
    #1;
    check("alloc_ready", alloc_ready, q.size() < DEPTH);
    @(posedge clk);
    #1;
    model_edge();
    check_outputs();
    clear_inputs();
  endtask

  task automatic set_alloc(input logic [31:0] pc, input logic [5:0] idx,
                           input logic [63:0] hist, input logic pred,
                           input logic [15:0] sum);
    alloc_valid = 1; alloc_pc = pc; alloc_index = idx;
    alloc_history = hist; alloc_prediction = pred; alloc_sum = sum;
  endtask

  task automatic set_resolve(input logic [31:0] pc, input logic taken);
    resolve_valid = 1; resolve_pc = pc; resolve_taken = taken;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    check_outputs();
    check("reset alloc_ready", alloc_ready, 1'b1);

    // Fill to DEPTH, then a 9th alloc must be refused.
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(32'h1000 + 32'(i * 4), 6'(i), 64'(i), 1'b1, 16'd10);
      step();
    end
    check("full after 8", full, 1'b1);
    check("count after 8", count, 4'd8);
    check("alloc_ready when full", alloc_ready, 1'b0);
    set_alloc(32'hDEAD, 6'd9, 64'h9, 1'b1, 16'd10);
    step();
    check("9th alloc refused", count, 4'd8);

    // Flush with same-cycle resolve and alloc: resolve trains, alloc dropped.
    set_resolve(32'h1000, 1'b1);
    set_alloc(32'hBEEF, 6'd3, 64'h3, 1'b0, 16'd5);
    flush = 1;
    step();
    check("flush train pulse", train_valid, 1'b1);
    check("flush empties", empty, 1'b1);

    // Correct prediction with large sum: no training.
    set_alloc(32'h2000, 6'd11, 64'hAA, 1'b1, 16'd200);
    step();
    set_resolve(32'h2000, 1'b1);
    step();
    check("confident correct no train", train_valid, 1'b0);

    // Mispredict with small sum: train + restore.
    set_alloc(32'h2004, 6'd21, 64'h0F, 1'b1, 16'd50);
    step();
    set_resolve(32'h2004, 1'b0);
    step();
    check("mispredict restore_history", restore_history, 64'h1E);
    check("mispredict train_index", train_index, 6'd21);

    // Mispredict squashes younger entries and a same-cycle alloc.
    for (int i = 0; i < 4; i++) begin
      set_alloc(32'h3000 + 32'(i * 4), 6'(30 + i), 64'(i + 100), 1'b0, 16'd300);
      step();
    end
    set_resolve(32'h3000, 1'b1);
    set_alloc(32'h3100, 6'd40, 64'h1, 1'b1, 16'd1);
    step();
    check("squash count", count, 4'd0);

    // Wrong PC, then resolve while empty.
    set_alloc(32'h4000, 6'd5, 64'h55, 1'b1, 16'd1);
    step();
    set_resolve(32'h4004, 1'b1);
    step();
    check("wrong pc flag", pc_mismatch, 1'b1);
    set_resolve(32'h4000, 1'b1);
    step();
    check("empty resolve flag sticky", pc_mismatch, 1'b1);

    // Reset mid-operation discards the pending pulse.
    set_alloc(32'h5000, 6'd7, 64'h77, 1'b0, 16'd2);
    step();
    set_alloc(32'h5004, 6'd8, 64'h78, 1'b0, 16'd2);
    set_resolve(32'h5000, 1'b0);
    step();
    rst_n = 1;
    #1;
    model_reset();
    check_outputs();
    #1;
    rst_n = 0;
    @(posedge clk);
    #1;

    // 20 back-to-back alloc/resolve pairs at the threshold boundary.
    set_alloc(32'h6000, 6'd0, 64'h1, 1'b1, -16'sd137);
    step();
    for (int i = 1; i <= 20; i++) begin
      set_resolve(q[0].pc, q[0].pred);
      set_alloc(32'h6000 + 32'(i * 4), 6'(i), 64'(i), 1'(i % 2), -16'sd137);
      step();
      check("boundary train", train_valid, 1'b1);
      check("boundary count", count, 4'd1);
    end

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 60) begin
        logic [15:0] sv;
        case ($urandom_range(0, 6))
          0: sv = 16'h8000;
          1: sv = -16'sd138;
          2: sv = -16'sd137;
          3: sv = 16'd137;
          4: sv = 16'd138;
          default: sv = 16'($urandom);
        endcase
        set_alloc($urandom, 6'($urandom), {$urandom, $urandom}, 1'($urandom), sv);
      end
      if ($urandom_range(0, 99) < 45) begin
        if (q.size() > 0 && $urandom_range(0, 19) != 0)
          set_resolve(q[0].pc, 1'($urandom));
        else if (q.size() > 0)
          set_resolve(q[0].pc ^ 32'h1, 1'($urandom));
        else
          set_resolve($urandom, 1'($urandom));
      end
      if ($urandom_range(0, 99) < 3) flush = 1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
